// File: rtl/mux_chip_nto1_arb_pkg.sv
// Shared constants and helpers for the N-to-1 registered mux chip.
package mux_chip_nto1_arb_pkg;

  typedef enum int unsigned {
    MUX_MODE_FIXED = 0,
    MUX_MODE_RR    = 1
  } mux_mode_e;

  // ceil(log2(n)), never below 1 so that select ports stay at least one bit wide
  function automatic int unsigned mux_clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned k = 0; k < 32; k++) begin
      if ((64'd1 << r) < 64'(n)) r++;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/mux_rr_grant.sv
// Combinational round-robin search: first valid channel at or after rr_ptr, wrapping.
module mux_rr_grant #(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned SEL_W    = 2
) (
  input  logic [CHANNELS-1:0] in_valid,
  input  logic [SEL_W-1:0]    rr_ptr,
  output logic [SEL_W-1:0]    grant,
  output logic                grant_valid
);

  always_comb begin
    int unsigned idx;
    idx         = 0;
    grant       = '0;
    grant_valid = 1'b0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      idx = (32'(rr_ptr) + k) % CHANNELS;
      if (!grant_valid && in_valid[idx]) begin
        grant       = SEL_W'(idx);
        grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_chip_nto1_arb.sv
// N-channel registered multiplexer with valid/ready handshake and either
// fixed (sel) or round-robin channel selection.
module mux_chip_nto1_arb
  import mux_chip_nto1_arb_pkg::*;
#(
  parameter  int unsigned WIDTH    = 8,
  parameter  int unsigned CHANNELS = 4,
  parameter  int unsigned MODE     = 1,
  localparam int unsigned SEL_W    = mux_clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic [SEL_W-1:0]          sel,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [SEL_W-1:0]          out_chan
);

  logic [SEL_W-1:0] rr_ptr;
  logic [SEL_W-1:0] grant;
  logic             grant_valid;
  logic             can_accept;
  logic             take;
  logic [WIDTH-1:0] grant_data;
  logic             unused_sel_ptr;

  // sel is ignored in round-robin mode and rr_ptr stays at zero in fixed mode
  assign unused_sel_ptr = ^{sel, rr_ptr};

  if (MODE == MUX_MODE_RR) begin : g_rr
    mux_rr_grant #(
      .CHANNELS (CHANNELS),
      .SEL_W    (SEL_W)
    ) u_grant (
      .in_valid    (in_valid),
      .rr_ptr      (rr_ptr),
      .grant       (grant),
      .grant_valid (grant_valid)
    );
  end else begin : g_fixed
    always_comb begin
      grant       = sel;
      grant_valid = (32'(sel) < CHANNELS) && in_valid[sel];
    end
  end

  assign can_accept = !out_valid || out_ready;

  always_comb begin
    in_ready = '0;
    if (!reset && can_accept && grant_valid) in_ready[grant] = 1'b1;
  end

  assign take = |in_ready;

  always_comb begin
    grant_data = '0;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      if (SEL_W'(c) == grant) grant_data = in_data[c*WIDTH +: WIDTH];
    end
  end

  // An accept takes priority over a drain, so a simultaneous pair keeps out_valid high
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
      rr_ptr    <= '0;
    end else if (take) begin
      out_valid <= 1'b1;
      out_data  <= grant_data;
      out_chan  <= grant;
      if (MODE == MUX_MODE_RR) begin
        rr_ptr <= (grant == SEL_W'(CHANNELS - 1)) ? '0 : grant + SEL_W'(1);
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_chip_nto1_arb.sv
// Directed vector bench for mux_chip_nto1_arb: one fixed-select and one round-robin instance.
module tb_mux_chip_nto1_arb;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] in_data;
  logic [3:0]  in_valid;
  logic [1:0]  sel;
  logic        out_ready;

  logic [3:0]  ir0, ir1;
  logic [7:0]  od0, od1;
  logic        ov0, ov1;
  logic [1:0]  oc0, oc1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mux_chip_nto1_arb #(.WIDTH(8), .CHANNELS(4), .MODE(0)) dut0 (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(ir0), .sel(sel), .out_data(od0), .out_valid(ov0),
    .out_ready(out_ready), .out_chan(oc0)
  );

  mux_chip_nto1_arb #(.WIDTH(8), .CHANNELS(4), .MODE(1)) dut1 (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(ir1), .sel(sel), .out_data(od1), .out_valid(ov1),
    .out_ready(out_ready), .out_chan(oc1)
  );

  // Inputs apply to the coming edge; expected outputs are the state before that edge.
  typedef struct {
    logic        rst;
    logic        m;
    logic [3:0]  v;
    logic [1:0]  sel;
    logic        rdy;
    logic [31:0] d;
    logic        co;
    logic [3:0]  e_ir;
    logic        e_ov;
    logic [7:0]  e_od;
    logic [1:0]  e_oc;
  } vec_t;

  localparam logic [31:0] D  = 32'h1312_1110;
  localparam logic [31:0] DA = 32'h00A5_0000;
  localparam logic [31:0] DC = 32'h1312_113C;

  vec_t tv[33];
  vec_t hs[9];

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec %0d: got %0h expected %0h", nm, idx, act, exp);
    end
  endtask

  task automatic apply(input vec_t t, input int idx);
    logic [3:0] a_ir;
    logic       a_ov;
    logic [7:0] a_od;
    logic [1:0] a_oc;
    @(negedge clk);
    reset     = t.rst;
    in_valid  = t.v;
    sel       = t.sel;
    out_ready = t.rdy;
    in_data   = t.d;
    #1;
    if (t.m) begin
      a_ir = ir1; a_ov = ov1; a_od = od1; a_oc = oc1;
    end else begin
      a_ir = ir0; a_ov = ov0; a_od = od0; a_oc = oc0;
    end
    chk("in_ready", idx, 32'(a_ir), 32'(t.e_ir));
    if (t.co) begin
      chk("out_valid", idx, 32'(a_ov), 32'(t.e_ov));
      chk("out_data",  idx, 32'(a_od), 32'(t.e_od));
      chk("out_chan",  idx, 32'(a_oc), 32'(t.e_oc));
    end
  endtask

  initial begin
    // rst m  v        sel    rdy   d   co   ir       ov    od     oc
    // reset with all valid high, MODE 0
    tv[0]  = '{1'b1, 1'b0, 4'b1111, 2'd0, 1'b1, D,  1'b0, 4'b0000, 1'b0, 8'h00, 2'd0};
    tv[1]  = '{1'b1, 1'b0, 4'b1111, 2'd0, 1'b1, D,  1'b1, 4'b0000, 1'b0, 8'h00, 2'd0};
    tv[2]  = '{1'b0, 1'b0, 4'b1111, 2'd0, 1'b1, D,  1'b1, 4'b0001, 1'b0, 8'h00, 2'd0};
    tv[3]  = '{1'b0, 1'b0, 4'b0000, 2'd0, 1'b1, D,  1'b1, 4'b0000, 1'b1, 8'h10, 2'd0};
    // fixed select ch2, then unselectable ch3
    tv[4]  = '{1'b0, 1'b0, 4'b0100, 2'd2, 1'b1, DA, 1'b1, 4'b0100, 1'b0, 8'h10, 2'd0};
    tv[5]  = '{1'b0, 1'b0, 4'b0100, 2'd3, 1'b1, DA, 1'b1, 4'b0000, 1'b1, 8'hA5, 2'd2};
    tv[6]  = '{1'b0, 1'b0, 4'b0100, 2'd3, 1'b1, DA, 1'b1, 4'b0000, 1'b0, 8'hA5, 2'd2};
    // round-robin, all valid
    tv[7]  = '{1'b1, 1'b1, 4'b1111, 2'd0, 1'b1, D,  1'b0, 4'b0000, 1'b0, 8'h00, 2'd0};
    tv[8]  = '{1'b0, 1'b1, 4'b1111, 2'd0, 1'b1, D,  1'b1, 4'b0001, 1'b0, 8'h00, 2'd0};
    tv[9]  = '{1'b0, 1'b1, 4'b1111, 2'd0, 1'b1, D,  1'b1, 4'b0010, 1'b1, 8'h10, 2'd0};
    tv[10] = '{1'b0, 1'b1, 4'b1111, 2'd0, 1'b1, D,  1'b1, 4'b0100, 1'b1, 8'h11, 2'd1};
    tv[11] = '{1'b0, 1'b1, 4'b1111, 2'd0, 1'b1, D,  1'b1, 4'b1000, 1'b1, 8'h12, 2'd2};
    tv[12] = '{1'b0, 1'b1, 4'b1111, 2'd0, 1'b1, D,  1'b1, 4'b0001, 1'b1, 8'h13, 2'd3};
    tv[13] = '{1'b0, 1'b1, 4'b1111, 2'd0, 1'b1, D,  1'b1, 4'b0010, 1'b1, 8'h10, 2'd0};
    // bring rr_ptr to 3, then skip/wrap over 1010
    tv[14] = '{1'b0, 1'b1, 4'b0100, 2'd0, 1'b1, D,  1'b1, 4'b0100, 1'b1, 8'h11, 2'd1};
    tv[15] = '{1'b0, 1'b1, 4'b1010, 2'd0, 1'b1, D,  1'b1, 4'b1000, 1'b1, 8'h12, 2'd2};
    tv[16] = '{1'b0, 1'b1, 4'b1010, 2'd0, 1'b1, D,  1'b1, 4'b0010, 1'b1, 8'h13, 2'd3};
    tv[17] = '{1'b0, 1'b1, 4'b1010, 2'd0, 1'b1, D,  1'b1, 4'b1000, 1'b1, 8'h11, 2'd1};
    tv[18] = '{1'b0, 1'b1, 4'b0000, 2'd0, 1'b1, D,  1'b1, 4'b0000, 1'b1, 8'h13, 2'd3};
    tv[19] = '{1'b0, 1'b1, 4'b0000, 2'd0, 1'b1, D,  1'b1, 4'b0000, 1'b0, 8'h13, 2'd3};
    // backpressure: load 3C, stall 5 cycles, then drain+accept together
    tv[20] = '{1'b0, 1'b1, 4'b0001, 2'd0, 1'b1, DC, 1'b1, 4'b0001, 1'b0, 8'h13, 2'd3};
    tv[21] = '{1'b0, 1'b1, 4'b1111, 2'd0, 1'b0, DC, 1'b1, 4'b0000, 1'b1, 8'h3C, 2'd0};
    tv[22] = '{1'b0, 1'b1, 4'b1111, 2'd1, 1'b0, DC, 1'b1, 4'b0000, 1'b1, 8'h3C, 2'd0};
    tv[23] = '{1'b0, 1'b1, 4'b1111, 2'd2, 1'b0, DC, 1'b1, 4'b0000, 1'b1, 8'h3C, 2'd0};
    tv[24] = '{1'b0, 1'b1, 4'b1111, 2'd3, 1'b0, DC, 1'b1, 4'b0000, 1'b1, 8'h3C, 2'd0};
    tv[25] = '{1'b0, 1'b1, 4'b1111, 2'd0, 1'b0, DC, 1'b1, 4'b0000, 1'b1, 8'h3C, 2'd0};
    tv[26] = '{1'b0, 1'b1, 4'b1111, 2'd0, 1'b1, DC, 1'b1, 4'b0010, 1'b1, 8'h3C, 2'd0};
    tv[27] = '{1'b0, 1'b1, 4'b0000, 2'd0, 1'b1, DC, 1'b1, 4'b0000, 1'b1, 8'h11, 2'd1};
    // reset while a beat is held
    tv[28] = '{1'b0, 1'b1, 4'b0100, 2'd0, 1'b1, D,  1'b1, 4'b0100, 1'b0, 8'h11, 2'd1};
    tv[29] = '{1'b0, 1'b1, 4'b0000, 2'd0, 1'b0, D,  1'b1, 4'b0000, 1'b1, 8'h12, 2'd2};
    tv[30] = '{1'b1, 1'b1, 4'b1111, 2'd0, 1'b0, D,  1'b1, 4'b0000, 1'b1, 8'h12, 2'd2};
    tv[31] = '{1'b0, 1'b1, 4'b1111, 2'd0, 1'b1, D,  1'b1, 4'b0001, 1'b0, 8'h00, 2'd0};
    tv[32] = '{1'b0, 1'b1, 4'b0000, 2'd0, 1'b1, D,  1'b1, 4'b0000, 1'b1, 8'h10, 2'd0};

    // MODE 0 stall with changing sel, then simultaneous drain and accept
    hs[0] = '{1'b1, 1'b0, 4'b0000, 2'd0, 1'b1, 32'h00A5_003C, 1'b0, 4'b0000, 1'b0, 8'h00, 2'd0};
    hs[1] = '{1'b0, 1'b0, 4'b0001, 2'd0, 1'b0, 32'h00A5_003C, 1'b1, 4'b0001, 1'b0, 8'h00, 2'd0};
    hs[2] = '{1'b0, 1'b0, 4'b1111, 2'd1, 1'b0, 32'h00A5_003C, 1'b1, 4'b0000, 1'b1, 8'h3C, 2'd0};
    hs[3] = '{1'b0, 1'b0, 4'b1111, 2'd2, 1'b0, 32'h00A5_003C, 1'b1, 4'b0000, 1'b1, 8'h3C, 2'd0};
    hs[4] = '{1'b0, 1'b0, 4'b1111, 2'd3, 1'b0, 32'h00A5_003C, 1'b1, 4'b0000, 1'b1, 8'h3C, 2'd0};
    hs[5] = '{1'b0, 1'b0, 4'b1111, 2'd0, 1'b0, 32'h00A5_003C, 1'b1, 4'b0000, 1'b1, 8'h3C, 2'd0};
    hs[6] = '{1'b0, 1'b0, 4'b0100, 2'd2, 1'b1, 32'h00A5_003C, 1'b1, 4'b0100, 1'b1, 8'h3C, 2'd0};
    hs[7] = '{1'b0, 1'b0, 4'b0000, 2'd2, 1'b1, 32'h00A5_003C, 1'b1, 4'b0000, 1'b1, 8'hA5, 2'd2};
    hs[8] = '{1'b0, 1'b0, 4'b0000, 2'd2, 1'b1, 32'h00A5_003C, 1'b1, 4'b0000, 1'b0, 8'hA5, 2'd2};

    reset     = 1'b1;
    in_valid  = '0;
    sel       = '0;
    out_ready = 1'b1;
    in_data   = '0;
    @(posedge clk);

    for (int i = 0; i < 33; i++) apply(tv[i], i);
    for (int i = 0; i < 9; i++) apply(hs[i], 100 + i);

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
